apb4_master_bridge: RTL and testbench

//  Upstream feeder for the APB4 slave interface/VIP. Converts a single-outstanding valid/ready

---
 rtl/apb4_master_bridge.sv | 218 +++++++++++++++++++++
 tb/tb_apb4_master_bridge.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_master_bridge.sv
// ---------------------------------------------------------------------------
// apb4_master_bridge
//
// Purpose:
//   Converts a single-outstanding valid/ready command channel into APB4
//   SETUP/ACCESS transfers. Read data and error come back on a valid/ready
//   response channel. Only one transfer is in flight at a time, so the
//   command and response channels never overlap.
//
//   FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE
//
// Optional feature (compile-time macro APB_MASTER_TIMEOUT_EN):
//   When defined, an ACCESS phase that sees PREADY low for TIMEOUT_CYCLES
//   cycles is aborted. The response then carries rsp_err=1 and rsp_rdata=0.
//   When undefined, ACCESS waits indefinitely for PREADY.
//
// Parameters:
//   addr_width      PADDR / cmd_addr width
//   data_width      PWDATA / PRDATA width (multiple of 8)
//   TIMEOUT_CYCLES  PREADY-low ACCESS cycles before abort (timeout build only)
//
// Ports:
//   PCLK, PRESET         clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_write            1 = write, 0 = read
//   cmd_addr/wdata/strb  command payload
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata, rsp_err   read data (0 for writes), PSLVERR or timeout
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB   APB4 request
//   PRDATA, PREADY, PSLVERR                       APB4 completion
// ---------------------------------------------------------------------------
module apb4_master_bridge #(
    parameter int addr_width     = 32,
    parameter int data_width     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    // command channel
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [addr_width-1:0]   cmd_addr,
    input  logic [data_width-1:0]   cmd_wdata,
    input  logic [data_width/8-1:0] cmd_strb,
    // response channel
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [data_width-1:0]   rsp_rdata,
    output logic                    rsp_err,
    // APB4 master port
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [addr_width-1:0]   PADDR,
    output logic [data_width-1:0]   PWDATA,
    output logic [data_width/8-1:0] PSTRB,
    input  logic [data_width-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int strb_width = data_width / 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]            state_reg;
    logic [1:0]            state_next;

    logic                  write_reg;
    logic [addr_width-1:0] addr_reg;
    logic [data_width-1:0] wdata_reg;
    logic [strb_width-1:0] strb_reg;
    logic [data_width-1:0] rdata_reg;
    logic                  err_reg;

    logic                  cmd_fire;
    logic                  access_done;
    logic                  timeout_hit;

    logic [data_width-1:0] wdata_masked;
    logic [strb_width-1:0] strb_masked;

    // ------------------------------------------------------------------
    // Reads must present zero data and zero strobes on the bus, so the
    // payload is masked per byte lane as it is captured. The registered
    // copy can then drive PWDATA/PSTRB directly.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < strb_width; gi++) begin : g_lane
            assign wdata_masked[gi*8 +: 8] = cmd_write ? cmd_wdata[gi*8 +: 8] : 8'h00;
            assign strb_masked[gi]         = cmd_write & cmd_strb[gi];
        end
    endgenerate

    // cmd_ready is forced low while reset is held, even though the state
    // register already sits in IDLE.
    assign cmd_ready   = (state_reg == ST_IDLE) & ~PRESET;
    assign cmd_fire    = cmd_valid & cmd_ready;
    // PSEL & PENABLE are both implied by ST_ACCESS, so PSLVERR/PRDATA are
    // only ever looked at on a genuine completion.
    assign access_done = (state_reg == ST_ACCESS) & PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int tmo_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [tmo_w-1:0] tmo_cnt_reg;

    // Abort on the edge where the stall count would reach TIMEOUT_CYCLES.
    // A PREADY=1 in the same cycle is a normal completion instead.
    assign timeout_hit = (state_reg == ST_ACCESS) & ~PREADY &
                         (tmo_cnt_reg == tmo_w'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == ST_SETUP) begin
            // SETUP is always followed by ACCESS: clear on ACCESS entry
            tmo_cnt_reg <= '0;
        end else if ((state_reg == ST_ACCESS) && !PREADY) begin
            tmo_cnt_reg <= tmo_cnt_reg + tmo_w'(1);
        end
    end
`else
    // No timeout in this build; the term only keeps the parameter referenced.
    assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_fire) begin
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (access_done || timeout_hit) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Command capture: held stable through SETUP and ACCESS
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            write_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            strb_reg  <= '0;
        end else if (cmd_fire) begin
            write_reg <= cmd_write;
            addr_reg  <= cmd_addr;
            wdata_reg <= wdata_masked;
            strb_reg  <= strb_masked;
        end
    end

    // ------------------------------------------------------------------
    // Response capture: loaded once per transfer, held through RESP
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else if (access_done) begin
            rdata_reg <= write_reg ? '0 : PRDATA;
            err_reg   <= PSLVERR;
        end else if (timeout_hit) begin
            rdata_reg <= '0;
            err_reg   <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from the state register, so PSEL/PENABLE/rsp_valid
    // fall as soon as the asynchronous reset clears the state.
    // ------------------------------------------------------------------
    assign PSEL      = (state_reg == ST_SETUP) | (state_reg == ST_ACCESS);
    assign PENABLE   = (state_reg == ST_ACCESS);
    assign PWRITE    = write_reg;
    assign PADDR     = addr_reg;
    assign PWDATA    = wdata_reg;
    assign PSTRB     = strb_reg;

    assign rsp_valid = (state_reg == ST_RESP);
    assign rsp_rdata = rdata_reg;
    assign rsp_err   = err_reg;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb4_master_bridge
//
// Directed, table-driven bench for apb4_master_bridge. Each table record is
// one command with its APB slave behaviour (wait states, PRDATA, PSLVERR)
// and the hand-computed bus and response values. Hand-written sequences
// cover back-to-back commands, reset during ACCESS and the PREADY-stuck case
// (timeout or indefinite wait depending on APB_MASTER_TIMEOUT_EN).
// ---------------------------------------------------------------------------
module tb_apb4_master_bridge;

    logic        PCLK;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    apb4_master_bridge #(
        .addr_width     (32),
        .data_width     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_strb  (cmd_strb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        int          hold;
        logic [31:0] exp_pwdata;
        logic [3:0]  exp_pstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [5];

    int total;
    int passed;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_strb  = v.strb;
        PREADY    = 1'b1;       // SETUP must ignore it
        PSLVERR   = 1'b1;
        PRDATA    = 32'hBAD0BAD0;
        rsp_ready = 1'b0;
        chk($sformatf("v%0d idle cmd_ready", idx), cmd_ready, 1'b1);
        tick();
        // accepted at this edge; scramble inputs to prove they were registered
        cmd_valid = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        cmd_strb  = 4'h0;
        cmd_write = ~v.wr;
        chk($sformatf("v%0d setup PSEL", idx), PSEL, 1'b1);
        chk($sformatf("v%0d setup PENABLE", idx), PENABLE, 1'b0);
        chk($sformatf("v%0d setup PADDR", idx), PADDR, v.addr);
        chk($sformatf("v%0d setup PWRITE", idx), PWRITE, v.wr);
        chk($sformatf("v%0d setup PWDATA", idx), PWDATA, v.exp_pwdata);
        chk($sformatf("v%0d setup PSTRB", idx), PSTRB, v.exp_pstrb);
        chk($sformatf("v%0d setup cmd_ready", idx), cmd_ready, 1'b0);
        for (int w = 0; w <= v.waits; w++) begin
            tick();
            chk($sformatf("v%0d access%0d PSEL", idx, w), PSEL, 1'b1);
            chk($sformatf("v%0d access%0d PENABLE", idx, w), PENABLE, 1'b1);
            chk($sformatf("v%0d access%0d PADDR", idx, w), PADDR, v.addr);
            chk($sformatf("v%0d access%0d PWDATA", idx, w), PWDATA, v.exp_pwdata);
            chk($sformatf("v%0d access%0d PSTRB", idx, w), PSTRB, v.exp_pstrb);
            chk($sformatf("v%0d access%0d rsp_valid", idx, w), rsp_valid, 1'b0);
            PREADY  = (w == v.waits);
            // wrong error/data while PREADY is low must be ignored
            PSLVERR = (w == v.waits) ? v.slverr : ~v.slverr;
            PRDATA  = (w == v.waits) ? v.prdata : ~v.prdata;
        end
        tick();
        PREADY  = 1'b0;
        PSLVERR = 1'b1;
        PRDATA  = 32'hA5A5A5A5;
        chk($sformatf("v%0d resp rsp_valid", idx), rsp_valid, 1'b1);
        chk($sformatf("v%0d resp PSEL", idx), PSEL, 1'b0);
        chk($sformatf("v%0d resp PENABLE", idx), PENABLE, 1'b0);
        chk($sformatf("v%0d resp cmd_ready", idx), cmd_ready, 1'b0);
        chk($sformatf("v%0d resp rsp_rdata", idx), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d resp rsp_err", idx), rsp_err, v.exp_err);
        for (int h = 0; h < v.hold; h++) begin
            tick();
            chk($sformatf("v%0d hold%0d rsp_valid", idx, h), rsp_valid, 1'b1);
            chk($sformatf("v%0d hold%0d rsp_err", idx, h), rsp_err, v.exp_err);
            chk($sformatf("v%0d hold%0d rsp_rdata", idx, h), rsp_rdata, v.exp_rdata);
            chk($sformatf("v%0d hold%0d cmd_ready", idx, h), cmd_ready, 1'b0);
            chk($sformatf("v%0d hold%0d PSEL", idx, h), PSEL, 1'b0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk($sformatf("v%0d after rsp_valid", idx), rsp_valid, 1'b0);
        chk($sformatf("v%0d after cmd_ready", idx), cmd_ready, 1'b1);
        $display("txn %0d: %s addr=0x%08h waits=%0d hold=%0d rdata=0x%08h err=%0b",
                 idx, v.wr ? "WR" : "RD", v.addr, v.waits, v.hold, v.exp_rdata, v.exp_err);
    endtask

    initial begin
        int first_setup;
        int second_setup;
        int first_resp;
        int overlap;
        int acc;

        total  = 0;
        passed = 0;

        //            wr    addr          wdata         strb  waits prdata        slverr hold pwdata        pstrb rdata         err
        vecs[0] = '{1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 32'h0000_0000, 1'b0, 0, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_2004, 32'hAAAA_5555, 4'hF, 3, 32'h1234_5678, 1'b0, 0, 32'h0000_0000, 4'h0, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_3008, 32'h0000_CAFE, 4'h3, 1, 32'h0000_0000, 1'b1, 4, 32'h0000_CAFE, 4'h3, 32'h0000_0000, 1'b1};
        vecs[3] = '{1'b0, 32'h0000_400C, 32'h1111_2222, 4'hC, 0, 32'hFFFF_FFFF, 1'b1, 2, 32'h0000_0000, 4'h0, 32'hFFFF_FFFF, 1'b1};
        vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'h0102_0304, 4'h5, 2, 32'h5555_5555, 1'b0, 1, 32'h0102_0304, 4'h5, 32'h0000_0000, 1'b0};

        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        cmd_strb  = 4'h0;
        rsp_ready = 1'b0;
        PRDATA    = 32'h0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        // reset state
        tick();
        tick();
        chk("reset cmd_ready", cmd_ready, 1'b0);
        chk("reset PSEL", PSEL, 1'b0);
        chk("reset PENABLE", PENABLE, 1'b0);
        chk("reset PWRITE", PWRITE, 1'b0);
        chk("reset PADDR", PADDR, 32'h0);
        chk("reset PWDATA", PWDATA, 32'h0);
        chk("reset PSTRB", PSTRB, 4'h0);
        chk("reset rsp_valid", rsp_valid, 1'b0);
        chk("reset rsp_rdata", rsp_rdata, 32'h0);
        chk("reset rsp_err", rsp_err, 1'b0);
        PRESET = 1'b0;
        tick();
        chk("post-reset cmd_ready", cmd_ready, 1'b1);

        for (int i = 0; i < 5; i++) begin
            run_vec(i, vecs[i]);
        end

        // back-to-back: cmd_valid held high, rsp_ready held high, PREADY=1
        first_setup  = -1;
        second_setup = -1;
        first_resp   = -1;
        overlap      = 0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0050;
        cmd_strb  = 4'hF;
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;
        PRDATA    = 32'h0000_0011;
        rsp_ready = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (PSEL && !PENABLE) begin
                if (first_setup < 0) first_setup = c;
                else if (second_setup < 0) second_setup = c;
            end
            if (rsp_valid) begin
                if (first_resp < 0) first_resp = c;
                if (PSEL || cmd_ready) overlap++;
            end
        end
        cmd_valid = 1'b0;
        tick();
        tick();
        rsp_ready = 1'b0;
        PREADY    = 1'b0;
        chk("b2b first SETUP cycle", first_setup, 1);
        chk("b2b first RESP cycle", first_resp, 3);
        chk("b2b second SETUP cycle", second_setup, 5);
        chk("b2b PSEL/cmd_ready during RESP", overlap, 0);
        chk("b2b drained cmd_ready", cmd_ready, 1'b1);
        $display("txn b2b: setup@%0d resp@%0d setup@%0d overlap=%0d",
                 first_setup, first_resp, second_setup, overlap);

        // reset pulse during ACCESS
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0070;
        cmd_wdata = 32'h7777_7777;
        PREADY    = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("rst-mid in ACCESS", PENABLE, 1'b1);
        #2;
        PRESET = 1'b1;
        #1;
        chk("rst-mid PSEL async", PSEL, 1'b0);
        chk("rst-mid PENABLE async", PENABLE, 1'b0);
        chk("rst-mid rsp_valid async", rsp_valid, 1'b0);
        chk("rst-mid cmd_ready", cmd_ready, 1'b0);
        tick();
        PRESET = 1'b0;
        PREADY = 1'b1;
        tick();
        chk("rst-rel cmd_ready", cmd_ready, 1'b1);
        chk("rst-rel rsp_valid", rsp_valid, 1'b0);
        chk("rst-rel PSEL", PSEL, 1'b0);
        tick();
        chk("rst-rel no stale rsp", rsp_valid, 1'b0);
        PREADY = 1'b0;
        $display("txn reset-mid-access: abandoned");

        // PREADY stuck low
        acc       = 0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0080;
        PRDATA    = 32'hFFFF_0000;
        PSLVERR   = 1'b0;
        PREADY    = 1'b0;
        tick();
        cmd_valid = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        for (int i = 0; i < 40; i++) begin
            tick();
            if (PENABLE) acc++;
            if (rsp_valid) break;
        end
        chk("timeout rsp_valid", rsp_valid, 1'b1);
        chk("timeout ACCESS cycles", acc, 16);
        chk("timeout rsp_err", rsp_err, 1'b1);
        chk("timeout rsp_rdata", rsp_rdata, 32'h0);
        chk("timeout PSEL", PSEL, 1'b0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("timeout after cmd_ready", cmd_ready, 1'b1);
        $display("txn timeout: access_cycles=%0d err=%0b", acc, rsp_err);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            if (PSEL && PENABLE && !rsp_valid) acc++;
        end
        chk("no-timeout ACCESS cycles", acc, 100);
        chk("no-timeout rsp_valid", rsp_valid, 1'b0);
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        tick();
        chk("no-timeout recover cmd_ready", cmd_ready, 1'b1);
        $display("txn stuck-pready: access_cycles=%0d", acc);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
